// File: rtl/controle_acesso_param.sv
// Sequential access-permission checker.
// A per-user permission table is consulted on each accepted request. The
// result is returned on a registered valid/ready response channel. Repeated
// denials trigger a timed lockout, and grant/deny statistics are kept with
// saturating counters.
module controle_acesso_param #(
    parameter int unsigned USER_W      = 3,
    parameter int unsigned FUNC_W      = 3,
    parameter int unsigned MAX_FAIL    = 3,
    parameter int unsigned LOCK_CYCLES = 16,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [USER_W-1:0]        req_user,
    input  logic [FUNC_W-1:0]        req_func,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic                     resp_grant,
    output logic [FUNC_W-1:0]        resp_func,
    input  logic                     cfg_we,
    input  logic [USER_W-1:0]        cfg_user,
    input  logic [(2**FUNC_W)-1:0]   cfg_mask,
    output logic                     locked,
    output logic [CNT_W-1:0]         grant_cnt,
    output logic [CNT_W-1:0]         deny_cnt
);

    localparam int unsigned ROWS   = 2**USER_W;
    localparam int unsigned MASK_W = 2**FUNC_W;
    localparam int unsigned FAIL_W = $clog2(MAX_FAIL + 1);
    localparam int unsigned TMR_W  = $clog2(LOCK_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        RESP,
        LOCK
    } state_t;

    // Legacy policy loaded into rows 0..7 on reset; bit f = function f allowed.
    function automatic logic [MASK_W-1:0] legacy_mask(input int unsigned row);
        logic [7:0] m;
        case (row)
            1:       m = 8'h5A;  // funcs 1,3,4,6
            3:       m = 8'h5E;  // funcs 1,2,3,4,6
            5:       m = 8'hFE;  // funcs 1..7
            6:       m = 8'h42;  // funcs 1,6
            default: m = 8'h00;
        endcase
        return MASK_W'(m);
    endfunction

    logic [MASK_W-1:0] table_q [ROWS];

    state_t            state_q, state_d;
    logic              grant_q, grant_d;
    logic [FUNC_W-1:0] func_q, func_d;
    logic [FAIL_W-1:0] fail_q, fail_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [CNT_W-1:0]  gcnt_q, gcnt_d;
    logic [CNT_W-1:0]  dcnt_q, dcnt_d;

    logic              lookup;

    // Function 0 is never granted regardless of the mask bit.
    assign lookup = table_q[req_user][req_func] & (req_func != '0);

    // Permission table: reset reloads the legacy policy; writes land at the edge,
    // so a same-cycle lookup of the written row still sees the old mask.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < ROWS; r++) begin
                table_q[USER_W'(r)] <= legacy_mask(r);
            end
        end else if (cfg_we) begin
            table_q[cfg_user] <= cfg_mask;
        end
    end

    // State, response and statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            func_q  <= '0;
            fail_q  <= '0;
            timer_q <= '0;
            gcnt_q  <= '0;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            func_q  <= func_d;
            fail_q  <= fail_d;
            timer_q <= timer_d;
            gcnt_q  <= gcnt_d;
            dcnt_q  <= dcnt_d;
        end
    end

    // Next-state logic: accept in IDLE, settle statistics at the response
    // handshake, and count down the lockout.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        func_d  = func_q;
        fail_d  = fail_q;
        timer_d = timer_q;
        gcnt_d  = gcnt_q;
        dcnt_d  = dcnt_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    grant_d = lookup;
                    func_d  = lookup ? req_func : '0;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    if (grant_q) begin
                        fail_d = '0;
                        if (gcnt_q != '1) begin
                            gcnt_d = gcnt_q + 1'b1;
                        end
                    end else begin
                        fail_d = fail_q + 1'b1;
                        if (dcnt_q != '1) begin
                            dcnt_d = dcnt_q + 1'b1;
                        end
                    end
                    if (fail_d == FAIL_W'(MAX_FAIL)) begin
                        state_d = LOCK;
                        timer_d = TMR_W'(LOCK_CYCLES);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            LOCK: begin
                // Timer enters at LOCK_CYCLES and leaves after the cycle at 1,
                // giving exactly LOCK_CYCLES cycles of lockout.
                timer_d = timer_q - 1'b1;
                if (timer_q == TMR_W'(1)) begin
                    state_d = IDLE;
                    fail_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign locked     = (state_q == LOCK);
    assign resp_grant = grant_q;
    assign resp_func  = func_q;
    assign grant_cnt  = gcnt_q;
    assign deny_cnt   = dcnt_q;

endmodule
